// File: rtl/dll_rx_fcdllp.sv
// dll_rx_fcdllp: parses received flow-control DLLPs for one VC, runs FC_INIT1/FC_INIT2/FC_DONE and holds partner credit limits.
// Define DLL_RX_FCDLLP_CRC_CHECK_EN to check the DLLP CRC-16 in bytes 4-5 and drop corrupted DLLPs.
module dll_rx_fcdllp #(
    parameter int VC_ID = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   dlc_state_i,
    input  logic [135:0] dllp_i,
    input  logic         dllp_valid_i,
    output logic [7:0]   ph_limit_o,
    output logic [11:0]  pd_limit_o,
    output logic [7:0]   nph_limit_o,
    output logic [11:0]  npd_limit_o,
    output logic [7:0]   cplh_limit_o,
    output logic [11:0]  cpld_limit_o,
    output logic         fc_init1_done_o,
    output logic         fc_init2_done_o,
    output logic         fc_update_o,
    output logic         crc_err_o
);
    typedef enum logic [1:0] {FC_IDLE, FC_INIT1, FC_INIT2, FC_DONE} fc_state_t;

    localparam logic [1:0] DL_INACTIVE = 2'b00;
    localparam logic [1:0] DL_INIT     = 2'b10;
    localparam logic [2:0] VC_SEL      = VC_ID[2:0];

    fc_state_t   r_state;
    logic [2:0]  r_mask;
    logic [7:0]  r_ph, r_nph, r_cplh;
    logic [11:0] r_pd, r_npd, r_cpld;
    logic        r_init1_done, r_init2_done, r_fc_update, r_crc_err;

    logic [7:0]  w_byte0, w_byte1, w_byte2, w_byte3;
    logic [1:0]  w_kind, w_idx;
    logic        w_is_init1, w_is_init2, w_is_upd, w_type_ok, w_hit, w_accept, w_write;
    logic        w_crc_ok, w_crc_err, w_changed;
    logic [7:0]  w_hdr, w_cur_hdr;
    logic [11:0] w_data, w_cur_data;
    logic [2:0]  w_mask_next;

    assign w_byte0 = dllp_i[135:128];
    assign w_byte1 = dllp_i[127:120];
    assign w_byte2 = dllp_i[119:112];
    assign w_byte3 = dllp_i[111:104];

    // Type nibble splits as {kind, fc class}: kind 01 InitFC1, 11 InitFC2, 10 UpdateFC; class 0 P, 1 NP, 2 Cpl.
    assign w_kind     = w_byte0[7:6];
    assign w_idx      = w_byte0[5:4];
    assign w_is_init1 = (w_kind == 2'b01);
    assign w_is_init2 = (w_kind == 2'b11);
    assign w_is_upd   = (w_kind == 2'b10);
    assign w_type_ok  = (w_kind != 2'b00) && (w_idx != 2'b11);
    assign w_hdr      = {w_byte1[5:0], w_byte2[7:6]};
    assign w_data     = {w_byte2[3:0], w_byte3};

    assign w_hit    = dllp_valid_i && w_type_ok && !w_byte0[3] && (w_byte0[2:0] == VC_SEL);
    assign w_accept = w_hit && w_crc_ok;

`ifdef DLL_RX_FCDLLP_CRC_CHECK_EN
    logic [15:0] w_crc_calc, w_crc_expect;
    logic        w_unused;

    // Bit-serial LFSR, byte 0 first and bit 0 of each byte first.
    function automatic logic [15:0] f_dllp_crc(input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ d[24 - 8*b + i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
            end
        end
        return c;
    endfunction

    always_comb begin
        w_crc_calc   = f_dllp_crc(dllp_i[135:104]);
        w_crc_expect = '0;
        for (int i = 0; i < 8; i++) begin
            w_crc_expect[8+i] = ~w_crc_calc[15-i];
            w_crc_expect[i]   = ~w_crc_calc[7-i];
        end
    end

    assign w_crc_ok  = (dllp_i[103:88] == w_crc_expect);
    assign w_crc_err = dllp_valid_i && !w_crc_ok;
    assign w_unused  = ^{dllp_i[127:126], dllp_i[117:116], dllp_i[87:0]};
`else
    logic w_unused;

    assign w_crc_ok  = 1'b1;
    assign w_crc_err = 1'b0;
    assign w_unused  = ^{dllp_i[127:126], dllp_i[117:116], dllp_i[103:0]};
`endif

    always_comb begin
        w_cur_hdr  = r_cplh;
        w_cur_data = r_cpld;
        case (w_idx)
            2'd0:    begin w_cur_hdr = r_ph;  w_cur_data = r_pd;  end
            2'd1:    begin w_cur_hdr = r_nph; w_cur_data = r_npd; end
            default: ;
        endcase
    end

    assign w_changed   = (w_hdr != w_cur_hdr) || (w_data != w_cur_data);
    assign w_mask_next = r_mask | (3'b001 << w_idx);
    assign w_write     = w_accept &&
                         (((r_state == FC_INIT1) && w_is_init1) ||
                          (((r_state == FC_INIT2) || (r_state == FC_DONE)) && w_is_upd));

    always_ff @(posedge clk) begin
        if (!rst_n || (dlc_state_i == DL_INACTIVE)) begin
            r_state      <= FC_IDLE;
            r_mask       <= 3'b000;
            r_ph         <= '0;
            r_pd         <= '0;
            r_nph        <= '0;
            r_npd        <= '0;
            r_cplh       <= '0;
            r_cpld       <= '0;
            r_init1_done <= 1'b0;
            r_init2_done <= 1'b0;
            r_fc_update  <= 1'b0;
            r_crc_err    <= 1'b0;
        end else begin
            r_fc_update <= w_write && w_is_upd && w_changed;
            r_crc_err   <= w_crc_err;
            if (w_write) begin
                case (w_idx)
                    2'd0:    begin r_ph   <= w_hdr; r_pd   <= w_data; end
                    2'd1:    begin r_nph  <= w_hdr; r_npd  <= w_data; end
                    2'd2:    begin r_cplh <= w_hdr; r_cpld <= w_data; end
                    default: ;
                endcase
            end
            case (r_state)
                FC_IDLE: begin
                    if (dlc_state_i == DL_INIT) r_state <= FC_INIT1;
                end
                FC_INIT1: begin
                    if (w_write) begin
                        r_mask <= w_mask_next;
                        if (w_mask_next == 3'b111) begin
                            r_state      <= FC_INIT2;
                            r_init1_done <= 1'b1;
                        end
                    end
                end
                FC_INIT2: begin
                    if (w_accept && (w_is_init2 || w_is_upd)) begin
                        r_state      <= FC_DONE;
                        r_init2_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ph_limit_o      = r_ph;
    assign pd_limit_o      = r_pd;
    assign nph_limit_o     = r_nph;
    assign npd_limit_o     = r_npd;
    assign cplh_limit_o    = r_cplh;
    assign cpld_limit_o    = r_cpld;
    assign fc_init1_done_o = r_init1_done;
    assign fc_init2_done_o = r_init2_done;
    assign fc_update_o     = r_fc_update;
    assign crc_err_o       = r_crc_err;
endmodule

// File: tb/tb_dll_rx_fcdllp.sv
// tb_dll_rx_fcdllp: directed DLLP stimulus with a queue-based scoreboard checked by a separate monitor.
// The corrupted-CRC expectation follows DLL_RX_FCDLLP_CRC_CHECK_EN.
module tb_dll_rx_fcdllp;
    localparam int VC = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   dlc = 2'b00;
    logic [135:0] dllp = '0;
    logic         valid = 1'b0;
    logic [7:0]   ph, nph, cplh;
    logic [11:0]  pd, npd, cpld;
    logic         d1, d2, upd, crc_err;

    always #5 clk = ~clk;

    dll_rx_fcdllp #(.VC_ID(VC)) dut (
        .clk(clk), .rst_n(rst_n), .dlc_state_i(dlc), .dllp_i(dllp), .dllp_valid_i(valid),
        .ph_limit_o(ph), .pd_limit_o(pd), .nph_limit_o(nph), .npd_limit_o(npd),
        .cplh_limit_o(cplh), .cpld_limit_o(cpld), .fc_init1_done_o(d1),
        .fc_init2_done_o(d2), .fc_update_o(upd), .crc_err_o(crc_err)
    );

    typedef struct {
        logic [63:0] v;
        int          due;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  e_ph, e_nph, e_cplh;
    logic [11:0] e_pd, e_npd, e_cpld;
    logic        e_d1, e_d2, e_upd, e_crc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t        x;
        logic [63:0] act;
        act = {ph, pd, nph, npd, cplh, cpld, d1, d2, upd, crc_err};
        while (q.size() > 0 && q[0].due <= cyc) begin
            x = q.pop_front();
            checks++;
            if (x.due != cyc || act !== x.v) begin
                errors++;
                $display("FAIL %s: cycle %0d due %0d got %h expected %h", x.name, cyc, x.due, act, x.v);
            end else begin
                $display("ok   %s: %h", x.name, act);
            end
        end
    end

    function automatic logic [15:0] crc16(input logic [31:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ d[24 - 8*b + i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h100B : 16'h0000);
            end
        end
        return c;
    endfunction

    // Reserved bits and the unused low bus are filled with ones/noise to prove they are ignored.
    function automatic logic [135:0] mk(input logic [3:0] typ, input logic b3, input logic [2:0] vc,
                                        input logic [7:0] h, input logic [11:0] d);
        logic [31:0] body;
        logic [15:0] c, f;
        body = {typ, b3, vc, 2'b11, h[7:2], h[1:0], 2'b11, d[11:8], d[7:0]};
        c = crc16(body);
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[8+i] = ~c[15-i];
            f[i]   = ~c[7-i];
        end
        return {body, f, {11{8'hA5}}};
    endfunction

    task automatic clr_exp();
        e_ph = '0; e_pd = '0; e_nph = '0; e_npd = '0; e_cplh = '0; e_cpld = '0;
        e_d1 = 1'b0; e_d2 = 1'b0; e_upd = 1'b0; e_crc = 1'b0;
    endtask

    task automatic step(input string name, input logic rst, input logic [1:0] d,
                        input logic v, input logic [135:0] p);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = rst; dlc = d; valid = v; dllp = p;
        x.v    = {e_ph, e_pd, e_nph, e_npd, e_cplh, e_cpld, e_d1, e_d2, e_upd, e_crc};
        x.due  = cyc + 1;
        x.name = name;
        q.push_back(x);
    endtask

    initial begin
        logic [135:0] bad;
        clr_exp();
        step("reset0", 1'b0, 2'b00, 1'b0, '0);
        step("reset1", 1'b0, 2'b10, 1'b1, mk(4'h4, 1'b0, 3'(VC), 8'h20, 12'h100));
        step("inactive_idle", 1'b1, 2'b00, 1'b0, '0);
        step("enter_init1", 1'b1, 2'b10, 1'b0, '0);

        // Everything here must be ignored in FC_INIT1
        step("init1_ign_updfc", 1'b1, 2'b10, 1'b1, mk(4'h8, 1'b0, 3'(VC), 8'h55, 12'h555));
        step("init1_ign_initfc2", 1'b1, 2'b10, 1'b1, mk(4'hD, 1'b0, 3'(VC), 8'h66, 12'h666));
        step("init1_ign_vc", 1'b1, 2'b10, 1'b1, mk(4'h4, 1'b0, 3'(VC + 1), 8'h77, 12'h777));
        step("init1_ign_bit3", 1'b1, 2'b10, 1'b1, mk(4'h4, 1'b1, 3'(VC), 8'h78, 12'h778));
        step("init1_ign_type7", 1'b1, 2'b10, 1'b1, mk(4'h7, 1'b0, 3'(VC), 8'h79, 12'h779));
        step("init1_ign_novalid", 1'b1, 2'b10, 1'b0, mk(4'h4, 1'b0, 3'(VC), 8'h7A, 12'h77A));

        e_ph = 8'h21; e_pd = 12'h101;
        step("init1_p_first", 1'b1, 2'b10, 1'b1, mk(4'h4, 1'b0, 3'(VC), 8'h21, 12'h101));
        e_ph = 8'h20; e_pd = 12'h100;
        step("init1_p_overwrite", 1'b1, 2'b10, 1'b1, mk(4'h4, 1'b0, 3'(VC), 8'h20, 12'h100));
        e_nph = 8'h10; e_npd = 12'h000;
        step("init1_np", 1'b1, 2'b10, 1'b1, mk(4'h5, 1'b0, 3'(VC), 8'h10, 12'h000));
        e_d1 = 1'b1;
        step("init1_cpl_done", 1'b1, 2'b10, 1'b1, mk(4'h6, 1'b0, 3'(VC), 8'h00, 12'h000));
        step("init2_ign_initfc1", 1'b1, 2'b10, 1'b1, mk(4'h4, 1'b0, 3'(VC), 8'h99, 12'h999));

        e_d2 = 1'b1; e_ph = 8'h30; e_pd = 12'h200; e_upd = 1'b1;
        step("init2_updfc_p", 1'b1, 2'b11, 1'b1, mk(4'h8, 1'b0, 3'(VC), 8'h30, 12'h200));
        e_upd = 1'b0;
        step("done_updfc_same", 1'b1, 2'b11, 1'b1, mk(4'h8, 1'b0, 3'(VC), 8'h30, 12'h200));
        e_npd = 12'h001; e_upd = 1'b1;
        step("done_updfc_np", 1'b1, 2'b11, 1'b1, mk(4'h9, 1'b0, 3'(VC), 8'h10, 12'h001));
        e_upd = 1'b0;
        step("done_ign_initfc2", 1'b1, 2'b11, 1'b1, mk(4'hC, 1'b0, 3'(VC), 8'hAA, 12'hAAA));
        step("done_ign_initfc1", 1'b1, 2'b11, 1'b1, mk(4'h6, 1'b0, 3'(VC), 8'hAB, 12'hAAB));
        e_cpld = 12'h040; e_upd = 1'b1;
        step("done_updfc_cpl_data", 1'b1, 2'b11, 1'b1, mk(4'hA, 1'b0, 3'(VC), 8'h00, 12'h040));
        e_upd = 1'b0;
        step("done_idle", 1'b1, 2'b11, 1'b0, '0);

        clr_exp();
        step("inactive_priority", 1'b1, 2'b00, 1'b1, mk(4'hA, 1'b0, 3'(VC), 8'h44, 12'h444));
        step("restart_init1", 1'b1, 2'b10, 1'b0, '0);
        e_cplh = 8'h01; e_cpld = 12'h002;
        step("b2b_cpl", 1'b1, 2'b10, 1'b1, mk(4'h6, 1'b0, 3'(VC), 8'h01, 12'h002));
        e_nph = 8'h03; e_npd = 12'h004;
        step("b2b_np", 1'b1, 2'b10, 1'b1, mk(4'h5, 1'b0, 3'(VC), 8'h03, 12'h004));
        e_ph = 8'h05; e_pd = 12'h006; e_d1 = 1'b1;
        step("b2b_p_done", 1'b1, 2'b10, 1'b1, mk(4'h4, 1'b0, 3'(VC), 8'h05, 12'h006));
        e_d2 = 1'b1;
        step("init2_initfc2_np", 1'b1, 2'b10, 1'b1, mk(4'hD, 1'b0, 3'(VC), 8'hEE, 12'hEEE));

        clr_exp();
        step("crc_inactive", 1'b1, 2'b00, 1'b0, '0);
        step("crc_init1", 1'b1, 2'b10, 1'b0, '0);
        bad = mk(4'h4, 1'b0, 3'(VC), 8'h20, 12'h100);
        bad[88] = ~bad[88];
`ifdef DLL_RX_FCDLLP_CRC_CHECK_EN
        e_crc = 1'b1;
`else
        e_ph = 8'h20; e_pd = 12'h100;
`endif
        step("crc_corrupt", 1'b1, 2'b10, 1'b1, bad);
        e_crc = 1'b0;
        step("crc_idle", 1'b1, 2'b10, 1'b0, '0);
        e_ph = 8'h22; e_pd = 12'h102;
        step("crc_good", 1'b1, 2'b10, 1'b1, mk(4'h4, 1'b0, 3'(VC), 8'h22, 12'h102));
        step("final_idle", 1'b1, 2'b10, 1'b0, '0);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dll_rx_fcdllp.md
Name: dll_rx_fcdllp

Overview:
Receive-side counterpart of the TX UpdateFC generator. Parses flow-control DLLPs from the PHY receive path for one VC and runs the FC initialization sequence (FC_INIT1 → FC_INIT2 → FC_DONE). Latches the link partner's advertised credit limits for P/NP/Cpl header and data. Sits between the PHY DLLP receive bus and the TL transmit credit gate; DLCMSM consumes the init-done flags.

Parameters:
VC_ID, 0, virtual channel this instance accepts (3 LSBs compared against DLLP byte0[2:0]).

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
dlc_state_i  input  2  DLCMSM state: 00 DL_INACTIVE, 01 DL_FEATURE, 10 DL_INIT, 11 DL_ACTIVE
dllp_i  input  136  PHY DLLP bus; DLLP bytes 0..5 at [135:88], byte0 = [135:128]; [87:0] ignored
dllp_valid_i  input  1  dllp_i holds a DLLP this cycle
ph_limit_o  output  8  posted header credit limit
pd_limit_o  output  12  posted data credit limit
nph_limit_o  output  8  non-posted header limit
npd_limit_o  output  12  non-posted data limit
cplh_limit_o  output  8  completion header limit
cpld_limit_o  output  12  completion data limit
fc_init1_done_o  output  1  all three InitFC1 received (level)
fc_init2_done_o  output  1  FC init complete (level)
fc_update_o  output  1  one-cycle pulse: a limit register changed from UpdateFC
crc_err_o  output  1  one-cycle pulse: CRC mismatch (only with the optional feature)

Behaviour:
- Reset (rst_n=0 at clk edge): all limits 0, all flags 0, FSM = FC_IDLE, received-mask = 3'b000.
- Decode byte0: [7:4] type, [3] must be 0, [2:0] VC. Types: 4/5/6 = InitFC1 P/NP/Cpl; C/D/E = InitFC2 P/NP/Cpl; 8/9/A = UpdateFC P/NP/Cpl. Any other type, byte0[3]=1, or VC≠VC_ID → ignored, no state change.
- Field extract: HdrFC = {byte1[5:0], byte2[7:6]}; DataFC = {byte2[3:0], byte3}; byte1[7:6] and byte2[5:4] ignored. Bytes 4–5 are CRC.
- An accepted DLLP is one with valid=1, a recognized type, and VC match (and passing CRC when the feature is on).
- All outputs are registered: effect is visible on the cycle after dllp_valid_i is sampled.
- FSM:
  - FC_IDLE: enters FC_INIT1 when dlc_state_i==DL_INIT.
  - FC_INIT1: an accepted InitFC1-X writes X's hdr/data limits and sets mask bit X. A repeated InitFC1-X overwrites the limits. InitFC2 and UpdateFC are ignored. When mask==3'b111 → FC_INIT2 and fc_init1_done_o=1. The transition happens in the same cycle as the third write.
  - FC_INIT2: accepted InitFC2 or UpdateFC of any type → FC_DONE and fc_init2_done_o=1. Limits are not modified by InitFC2. An UpdateFC in this state also updates limits as in FC_DONE. InitFC1 is ignored.
  - FC_DONE: accepted UpdateFC-X writes X's limits. fc_update_o pulses only if the new value differs from the stored one. InitFC1/InitFC2 are ignored.
- From any state, dlc_state_i==DL_INACTIVE: next cycle all limits cleared, flags cleared, mask cleared, FSM = FC_IDLE. This has priority over a simultaneous DLLP.
- Limit value 0 is stored as-is; the consumer interprets 0 as infinite credit. No arithmetic or wrap is performed here.
- At most one DLLP per cycle; back-to-back valid cycles are each processed.

Optional Feature:
DLL_RX_FCDLLP_CRC_CHECK_EN
- With the macro: compute the DLLP CRC-16 (poly 0x100B, seed 0xFFFF, PCIe DLLP bit ordering, result inverted) over bytes 0–3 and compare with bytes 4–5. On mismatch, discard the DLLP (no state or limit change) and pulse crc_err_o for one cycle. The comparison is combinational, so latency stays 1 cycle.
- Without the macro: CRC bytes are ignored and crc_err_o is tied to 0.

Test Plan:
- Reset, then dlc_state_i=10 and send InitFC1 P(H=0x20,D=0x100), NP(0x10,0x000), Cpl(0x00,0x000) → after the third DLLP, fc_init1_done_o=1 and ph=0x20, pd=0x100, nph=0x10, npd=0, cplh=0, cpld=0.
- In FC_INIT2, send UpdateFC-P(0x30,0x200) → fc_init2_done_o=1, ph=0x30, pd=0x200, fc_update_o pulse. Then send UpdateFC-P(0x30,0x200) again → no pulse.
- In FC_INIT1, send UpdateFC-P and InitFC2-NP → limits unchanged, fc_init1_done_o remains 0. Send InitFC1 with VC=VC_ID+1 → ignored.
- In FC_DONE, assert dlc_state_i=00 in the same cycle as a valid UpdateFC-Cpl → next cycle all limits 0, both done flags 0. Return to 10 → FSM restarts in FC_INIT1.
- Feature on: InitFC1-P with a corrupted CRC byte → crc_err_o pulses once and ph/pd unchanged. Resend with correct CRC → accepted. Feature off: same corrupted DLLP is accepted and crc_err_o stays 0.
- Back-to-back valid cycles: InitFC1-Cpl, InitFC1-NP, InitFC1-P on consecutive clocks → fc_init1_done_o rises exactly on the cycle after the third DLLP.
